// File: rtl/dmac_channel.sv
// Single DMA channel acting as an AHB-Lite master. Copies T_Size words from
// S_Address to D_Address. Full bursts of Beff words are staged through an
// internal FIFO, and the words left over are moved as single transfers.
module dmac_channel #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        channel_en,
  input  logic        readyIn,
  input  logic [1:0]  HResp,
  input  logic [31:0] R_Data,
  input  logic [31:0] S_Address,
  input  logic [31:0] D_Address,
  input  logic [31:0] T_Size,
  input  logic [31:0] B_Size,
  output logic        irq,
  output logic        write,
  output logic [1:0]  HTrans,
  output logic [31:0] MAddress,
  output logic [31:0] MWData
);

  localparam int unsigned PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] DEPTH32 = 32'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_BURST,
    S_RD_LAST,
    S_WR_BURST,
    S_WR_LAST,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  state_e        state_q, state_d;
  logic [31:0]   src_q, src_d;
  logic [31:0]   dst_q, dst_d;
  logic [31:0]   left_q, left_d;   // words not yet written
  logic [31:0]   beff_q, beff_d;   // effective burst length
  logic [31:0]   len_q, len_d;     // length of the chunk in flight
  logic [31:0]   beat_q, beat_d;   // address phases accepted in this chunk
  logic [31:0]   wdata_q, wdata_d;
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [31:0]   fifo_mem [FIFO_DEPTH];

  logic        push, pop, flush, data_phase;
  logic [31:0] beff_in;
  htrans_e     htrans_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Clamp the requested burst length into 1..FIFO_DEPTH.
  always_comb begin
    beff_in = B_Size;
    if (B_Size == '0)
      beff_in = 32'd1;
    else if (B_Size > DEPTH32)
      beff_in = DEPTH32;
  end

  // Next-state, datapath control and bus outputs.
  // Rather than dividing T_Size by Beff up front, the remaining word count is
  // tracked: a full burst is issued while at least Beff words remain, then
  // single transfers; this yields the same quotient/remainder sequence.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    left_d     = left_q;
    beff_d     = beff_q;
    len_d      = len_q;
    beat_d     = beat_q;
    wdata_d    = wdata_q;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    data_phase = 1'b0;
    htrans_c   = HT_IDLE;
    write      = 1'b0;
    MAddress   = '0;
    irq        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (channel_en) begin
          src_d  = S_Address;
          dst_d  = D_Address;
          left_d = T_Size;
          beff_d = beff_in;
          beat_d = '0;
          if (T_Size == '0) begin
            state_d = S_DONE;
          end else begin
            len_d   = (T_Size >= beff_in) ? beff_in : 32'd1;
            state_d = S_RD_BURST;
          end
        end
      end
      S_RD_BURST: begin
        htrans_c   = (beat_q == '0) ? HT_NONSEQ : HT_SEQ;
        MAddress   = src_q;
        data_phase = (beat_q != '0);
        if (readyIn) begin
          push  = (beat_q != '0);
          src_d = src_q + 32'd4;
          if (beat_q == len_q - 32'd1) begin
            beat_d  = '0;
            state_d = S_RD_LAST;
          end else begin
            beat_d = beat_q + 32'd1;
          end
        end
      end
      S_RD_LAST: begin
        data_phase = 1'b1;
        if (readyIn) begin
          push    = 1'b1;
          state_d = S_WR_BURST;
        end
      end
      S_WR_BURST: begin
        htrans_c   = (beat_q == '0) ? HT_NONSEQ : HT_SEQ;
        write      = 1'b1;
        MAddress   = dst_q;
        data_phase = (beat_q != '0);
        if (readyIn) begin
          pop     = 1'b1;
          wdata_d = fifo_mem[rp_q];
          dst_d   = dst_q + 32'd4;
          if (beat_q == len_q - 32'd1) begin
            beat_d  = '0;
            state_d = S_WR_LAST;
          end else begin
            beat_d = beat_q + 32'd1;
          end
        end
      end
      S_WR_LAST: begin
        data_phase = 1'b1;
        if (readyIn) begin
          left_d = left_q - len_q;
          if (left_d == '0) begin
            state_d = S_DONE;
          end else begin
            len_d   = (left_d >= beff_q) ? beff_q : 32'd1;
            state_d = S_RD_BURST;
          end
        end
      end
      S_DONE: begin
        irq = 1'b1;
        if (!channel_en)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // An ERROR response in any data phase aborts the whole transfer.
    if (data_phase && HResp == 2'b01) begin
      state_d = S_DONE;
      push    = 1'b0;
      pop     = 1'b0;
      flush   = 1'b1;
      beat_d  = '0;
      wdata_d = wdata_q;
    end

    HTrans = htrans_c;
    MWData = wdata_q;
  end

  // FIFO pointer update: flush on abort, otherwise advance on push/pop.
  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (flush) begin
      wp_d = '0;
      rp_d = '0;
    end else begin
      if (push) wp_d = ptr_inc(wp_q);
      if (pop)  rp_d = ptr_inc(rp_q);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      left_q  <= '0;
      beff_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      wdata_q <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      left_q  <= left_d;
      beff_q  <= beff_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      wdata_q <= wdata_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !rst)
      fifo_mem[wp_q] <= R_Data;
  end

endmodule

// File: tb/tb_dmac_channel.sv
// Bench for dmac_channel: behavioural AHB memory slave plus a reference
// model that derives the expected bus trace and destination contents from
// the transfer parameters.
module tb_dmac_channel;

  localparam int unsigned MEM_WORDS = 4096;

  logic        clk = 1'b0;
  logic        rst, channel_en, readyIn;
  logic [1:0]  HResp;
  logic [31:0] R_Data, S_Address, D_Address, T_Size, B_Size;
  logic        irq, write;
  logic [1:0]  HTrans;
  logic [31:0] MAddress, MWData;

  always #5 clk = ~clk;

  dmac_channel #(.FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .channel_en(channel_en), .readyIn(readyIn),
    .HResp(HResp), .R_Data(R_Data), .S_Address(S_Address),
    .D_Address(D_Address), .T_Size(T_Size), .B_Size(B_Size), .irq(irq),
    .write(write), .HTrans(HTrans), .MAddress(MAddress), .MWData(MWData)
  );

  // Memory slave: registers the address phase, serves/absorbs the data phase.
  logic [31:0] mem [MEM_WORDS];
  logic        dph_valid, dph_write;
  logic [11:0] dph_idx = '0;
  logic        host_we = 1'b0;
  logic [11:0] host_idx = '0;
  logic [31:0] host_data = '0;

  always @(posedge clk) begin
    if (host_we) mem[host_idx] = host_data;
    if (rst) begin
      dph_valid <= 1'b0;
    end else if (readyIn) begin
      if (dph_valid && dph_write) mem[dph_idx] = MWData;
      dph_valid <= HTrans[1];
      dph_write <= write;
      dph_idx   <= MAddress[13:2];
    end
  end

  assign R_Data = mem[dph_idx];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] vals[$];

  typedef struct {
    logic [1:0]  ht;
    logic        wr;
    logic [31:0] addr;
    logic        wchk;
    logic [31:0] wd;
  } beat_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic poke(input int unsigned idx, input logic [31:0] v);
    host_idx  = 12'(idx % MEM_WORDS);
    host_data = v;
    host_we   = 1'b1;
    @(posedge clk); #1;
    host_we   = 1'b0;
  endtask

  // Source words from vals, cleared destination and a sentinel past its end.
  task automatic load_region(input int unsigned sidx, input int unsigned didx, input int unsigned t);
    for (int unsigned i = 0; i < t; i++) begin
      poke(sidx + i, vals[i]);
      poke(didx + i, 32'h0);
    end
    poke(didx + t, 32'hDEAD_BEEF);
  endtask

  task automatic check_dest(input int unsigned didx, input int unsigned t);
    for (int unsigned i = 0; i < t; i++)
      check("dst_word", mem[(didx + i) % MEM_WORDS], vals[i]);
    check("dst_sentinel", mem[(didx + t) % MEM_WORDS], 32'hDEAD_BEEF);
  endtask

  // mode 0: zero-wait, full cycle trace compare; 1: random wait states and an
  // early channel_en drop; 2: one 2-cycle stall mid write burst.
  task automatic run_case(input logic [31:0] s, input logic [31:0] d,
                          input int unsigned t, input int unsigned b, input int mode);
    int unsigned sidx, didx, beff, nb, rem, w, idx, cyc, stall_left;
    int unsigned chunks[$];
    logic [31:0] sa, da, pv_addr, pv_wd;
    logic [1:0]  pv_ht;
    logic        pv_wr, prev_rdy, stalled, done;
    beat_t       e;
    beat_t       trace[$];

    while (vals.size() < t) vals.push_back($urandom);
    sidx = 32'(s[13:2]);
    didx = 32'(d[13:2]);
    load_region(sidx, didx, t);

    beff = (b == 0) ? 1 : ((b > 16) ? 16 : b);
    nb   = t / beff;
    rem  = t % beff;
    for (int unsigned i = 0; i < nb; i++)  chunks.push_back(beff);
    for (int unsigned i = 0; i < rem; i++) chunks.push_back(1);
    sa = s; da = d; w = 0;
    foreach (chunks[c]) begin
      for (int unsigned k = 0; k < chunks[c]; k++) begin
        e = '{(k == 0) ? 2'b10 : 2'b11, 1'b0, sa, 1'b0, 32'h0};
        trace.push_back(e);
        sa += 32'd4;
      end
      e = '{2'b00, 1'b0, 32'h0, 1'b0, 32'h0};
      trace.push_back(e);
      for (int unsigned k = 0; k < chunks[c]; k++) begin
        e = '{(k == 0) ? 2'b10 : 2'b11, 1'b1, da, (k > 0), (k > 0) ? vals[w + k - 1] : 32'h0};
        trace.push_back(e);
        da += 32'd4;
      end
      e = '{2'b00, 1'b0, 32'h0, 1'b1, vals[w + chunks[c] - 1]};
      trace.push_back(e);
      w += chunks[c];
    end

    S_Address = s; D_Address = d; T_Size = t; B_Size = b;
    channel_en = 1'b1;
    readyIn    = 1'b1;
    prev_rdy = 1'b1; stalled = 1'b0; stall_left = 0; idx = 0; cyc = 0; done = 1'b0;
    pv_ht = '0; pv_wr = 1'b0; pv_addr = '0; pv_wd = '0;
    while (!done) begin
      @(posedge clk); #1;
      cyc++;
      if (mode == 0) begin
        if (idx < trace.size()) begin
          check("irq_busy", 32'(irq), 32'h0);
          check("htrans", 32'(HTrans), 32'(trace[idx].ht));
          check("hwrite", 32'(write), 32'(trace[idx].wr));
          if (trace[idx].ht != 2'b00) check("haddr", MAddress, trace[idx].addr);
          if (trace[idx].wchk) check("hwdata", MWData, trace[idx].wd);
          idx++;
        end else begin
          check("irq_done", 32'(irq), 32'h1);
          check("done_htrans", 32'(HTrans), 32'h0);
          done = 1'b1;
        end
      end else begin
        if (!prev_rdy && !irq) begin
          check("hold_htrans", 32'(HTrans), 32'(pv_ht));
          check("hold_write", 32'(write), 32'(pv_wr));
          check("hold_haddr", MAddress, pv_addr);
          check("hold_hwdata", MWData, pv_wd);
        end
        if (irq) done = 1'b1;
      end
      pv_ht = HTrans; pv_wr = write; pv_addr = MAddress; pv_wd = MWData;
      if (mode == 1) begin
        readyIn = ($urandom_range(0, 3) != 0);
        if (cyc == 3) channel_en = 1'b0;
      end else if (mode == 2) begin
        if (!stalled && write && HTrans != 2'b00 && MAddress == d + 32'd8) begin
          stalled    = 1'b1;
          stall_left = 2;
        end
        readyIn = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end
      prev_rdy = readyIn;
      if (cyc > 3000 && !done) begin
        check("timeout_irq", 32'(irq), 32'h1);
        done = 1'b1;
      end
    end
    readyIn = 1'b1;
    if (mode == 2) check("stall_hit", 32'(stalled), 32'h1);
    check_dest(didx, t);
    channel_en = 1'b0;
    @(posedge clk); #1;
    check("irq_clear", 32'(irq), 32'h0);
    vals.delete();
  endtask

  initial begin
    logic saw_write;
    rst = 1'b1; channel_en = 1'b0; readyIn = 1'b1; HResp = 2'b00;
    S_Address = '0; D_Address = '0; T_Size = '0; B_Size = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_write", 32'(write), 32'h0);
    check("rst_htrans", 32'(HTrans), 32'h0);
    check("rst_haddr", MAddress, 32'h0);
    check("rst_hwdata", MWData, 32'h0);
    rst = 1'b0;

    // Four 4-beat bursts plus two singles with fixed data.
    vals = '{32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'h99AABBCC, 32'h123, 32'h456};
    for (int unsigned i = 1; i <= 12; i++) vals.push_back(i);
    run_case(32'h0, 32'h1000, 18, 4, 0);

    run_case(32'h40, 32'h1800, 4, 4, 0);       // one burst each way, irq after 10 cycles
    run_case(32'h80, 32'h1900, 3, 8, 0);       // three singles
    run_case(32'h100, 32'h1A00, 8, 4, 2);      // stall mid write burst
    run_case(32'h0, 32'h1B00, 0, 4, 0);        // empty transfer
    run_case(32'hFFFF_FFF8, 32'h2000, 6, 4, 0); // source pointer wraps
    run_case(32'h200, 32'h2400, 3, 0, 0);      // B_Size 0 behaves as 1
    run_case(32'h0, 32'h1000, 40, 40, 0);      // B_Size clamps to 16

    // ERROR response on the second read beat's data phase.
    for (int i = 0; i < 8; i++) vals.push_back($urandom);
    load_region(64, 3072, 8);
    S_Address = 32'h100; D_Address = 32'h3000; T_Size = 8; B_Size = 4;
    channel_en = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("err_pre_haddr", MAddress, 32'h108);
    HResp = 2'b01;
    @(posedge clk); #1;
    HResp = 2'b00;
    check("err_htrans", 32'(HTrans), 32'h0);
    check("err_irq", 32'(irq), 32'h1);
    saw_write = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (write || HTrans != 2'b00) saw_write = 1'b1;
    end
    check("err_no_write", 32'(saw_write), 32'h0);
    check("err_dst_untouched", mem[3072], 32'h0);
    channel_en = 1'b0;
    @(posedge clk); #1;
    check("err_irq_clear", 32'(irq), 32'h0);
    vals.delete();

    // Reset in the middle of a write burst.
    for (int i = 0; i < 8; i++) vals.push_back($urandom | 32'h1);
    load_region(128, 3328, 8);
    S_Address = 32'h200; D_Address = 32'h3400; T_Size = 8; B_Size = 8;
    channel_en = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    check("prerst_write", 32'(write), 32'h1);
    check("prerst_hwdata", MWData, vals[1]);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_irq", 32'(irq), 32'h0);
    check("midrst_write", 32'(write), 32'h0);
    check("midrst_htrans", 32'(HTrans), 32'h0);
    check("midrst_haddr", MAddress, 32'h0);
    check("midrst_hwdata", MWData, 32'h0);
    rst = 1'b0; channel_en = 1'b0;
    @(posedge clk); #1;
    check("postrst_htrans", 32'(HTrans), 32'h0);
    vals.delete();

    // Randomized transfers, some with random wait states.
    for (int r = 0; r < 10; r++) begin
      run_case(32'($urandom_range(0, 1000)) * 32'd4,
               32'h2000 + 32'($urandom_range(0, 900)) * 32'd4,
               $urandom_range(0, 40), $urandom_range(0, 20),
               int'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
